// File: rtl/reg_file_if.sv
// ROB/Decoder -> register file bus: commit and rename updates, flush, and two
// combinational source-operand query ports.
interface reg_file_if #(
  parameter int ROB_SIZE_BIT = 5
);
  logic                    rob_clear;
  logic                    is_update_val;
  logic [4:0]              update_val_id;
  logic [ROB_SIZE_BIT-1:0] update_val_dep;
  logic [31:0]             update_val;
  logic                    is_update_dep;
  logic [4:0]              update_dep_id;
  logic [ROB_SIZE_BIT-1:0] update_dep;
  logic [4:0]              qry1_id;
  logic [31:0]             qry1_val;
  logic                    qry1_has_dep;
  logic [ROB_SIZE_BIT-1:0] qry1_dep;
  logic [4:0]              qry2_id;
  logic [31:0]             qry2_val;
  logic                    qry2_has_dep;
  logic [ROB_SIZE_BIT-1:0] qry2_dep;

  modport master (
    output rob_clear, is_update_val, update_val_id, update_val_dep, update_val,
           is_update_dep, update_dep_id, update_dep, qry1_id, qry2_id,
    input  qry1_val, qry1_has_dep, qry1_dep, qry2_val, qry2_has_dep, qry2_dep
  );

  modport slave (
    input  rob_clear, is_update_val, update_val_id, update_val_dep, update_val,
           is_update_dep, update_dep_id, update_dep, qry1_id, qry2_id,
    output qry1_val, qry1_has_dep, qry1_dep, qry2_val, qry2_has_dep, qry2_dep
  );
endinterface

// File: rtl/reg_file.sv
// Architectural register file with per-register rename tags; queries return
// either a ready value (with same-cycle commit bypass) or the ROB tag to wait on.
module reg_file #(
  parameter int ROB_SIZE_BIT = 5
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       rdy_in,
  reg_file_if.slave  bus
);
  typedef struct packed {
    logic [31:0]             val;
    logic                    has_dep;
    logic [ROB_SIZE_BIT-1:0] dep;
  } qry_t;

  logic [31:0]             val_q [32];
  logic [31:0]             val_d [32];
  logic [31:0]             busy_q;
  logic [31:0]             busy_d;
  logic [ROB_SIZE_BIT-1:0] dep_q [32];
  logic [ROB_SIZE_BIT-1:0] dep_d [32];
  qry_t                    qry1_s;
  qry_t                    qry2_s;

  // A commit only clears busy when it comes from the rename still on record;
  // a younger rename of the same register keeps its tag.
  function automatic qry_t lookup(input logic [4:0] id);
    qry_t r;
    r = '{val: 32'd0, has_dep: 1'b0, dep: '0};
    if (id == 5'd0) begin
      r = '{val: 32'd0, has_dep: 1'b0, dep: '0};
    end else if (bus.is_update_val && (bus.update_val_id == id) &&
                 (!busy_q[id] || (dep_q[id] == bus.update_val_dep))) begin
      r = '{val: bus.update_val, has_dep: 1'b0, dep: '0};
    end else if (busy_q[id]) begin
      r = '{val: val_q[id], has_dep: 1'b1, dep: dep_q[id]};
    end else begin
      r = '{val: val_q[id], has_dep: 1'b0, dep: '0};
    end
    return r;
  endfunction

  // Next state: commit first, then flush or rename overrides the busy/tag.
  always_comb begin
    val_d  = val_q;
    busy_d = busy_q;
    dep_d  = dep_q;
    if (rdy_in) begin
      if (bus.is_update_val && (bus.update_val_id != 5'd0)) begin
        val_d[bus.update_val_id] = bus.update_val;
        if (busy_q[bus.update_val_id] &&
            (dep_q[bus.update_val_id] == bus.update_val_dep)) begin
          busy_d[bus.update_val_id] = 1'b0;
        end else begin
          busy_d[bus.update_val_id] = busy_q[bus.update_val_id];
        end
      end else begin
        val_d = val_q;
      end
      if (bus.rob_clear) begin
        busy_d = 32'd0;
      end else if (bus.is_update_dep && (bus.update_dep_id != 5'd0)) begin
        busy_d[bus.update_dep_id] = 1'b1;
        dep_d[bus.update_dep_id]  = bus.update_dep;
      end else begin
        dep_d = dep_q;
      end
    end else begin
      val_d  = val_q;
      busy_d = busy_q;
      dep_d  = dep_q;
    end
  end

  // State register with asynchronous clear.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      val_q  <= '{default: 32'd0};
      busy_q <= 32'd0;
      dep_q  <= '{default: '0};
    end else begin
      val_q  <= val_d;
      busy_q <= busy_d;
      dep_q  <= dep_d;
    end
  end

  // Combinational operand lookup for both decoder ports.
  always_comb begin
    qry1_s = lookup(bus.qry1_id);
    qry2_s = lookup(bus.qry2_id);
  end

  assign bus.qry1_val     = qry1_s.val;
  assign bus.qry1_has_dep = qry1_s.has_dep;
  assign bus.qry1_dep     = qry1_s.dep;
  assign bus.qry2_val     = qry2_s.val;
  assign bus.qry2_has_dep = qry2_s.has_dep;
  assign bus.qry2_dep     = qry2_s.dep;
endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios plus randomized traffic
// checked against a pending-tag model of the register file.
module tb_reg_file;
  logic clk_in = 1'b0;
  logic rst_in;
  logic rdy_in;
  int   vectors = 0;
  int   miscompares = 0;

  reg_file_if #(.ROB_SIZE_BIT(5)) bus ();

  reg_file #(.ROB_SIZE_BIT(5)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  // Model: committed value per register, and the ROB tag it waits on (-1 = ready).
  logic [31:0] m_val [32];
  int          m_pend [32];

  function automatic void m_reset();
    for (int i = 0; i < 32; i++) begin
      m_val[i]  = 32'd0;
      m_pend[i] = -1;
    end
  endfunction

  function automatic void m_query(input logic [4:0] id, output logic [31:0] v,
                                  output logic h, output logic [4:0] d);
    int t;
    v = 32'd0; h = 1'b0; d = 5'd0;
    if (id == 5'd0) return;
    if (bus.is_update_val && bus.update_val_id == id &&
        (m_pend[id] < 0 || m_pend[id] == int'(bus.update_val_dep))) begin
      v = bus.update_val;
      return;
    end
    v = m_val[id];
    if (m_pend[id] >= 0) begin
      h = 1'b1;
      t = m_pend[id];
      d = t[4:0];
    end
  endfunction

  function automatic void m_clock();
    if (!rdy_in) return;
    if (bus.is_update_val && bus.update_val_id != 5'd0) begin
      m_val[bus.update_val_id] = bus.update_val;
      if (m_pend[bus.update_val_id] == int'(bus.update_val_dep))
        m_pend[bus.update_val_id] = -1;
    end
    if (bus.rob_clear) begin
      for (int i = 0; i < 32; i++) m_pend[i] = -1;
    end else if (bus.is_update_dep && bus.update_dep_id != 5'd0) begin
      m_pend[bus.update_dep_id] = int'(bus.update_dep);
    end
  endfunction

  task automatic idle();
    bus.rob_clear = 1'b0;
    bus.is_update_val = 1'b0; bus.update_val_id = 5'd0; bus.update_val_dep = 5'd0;
    bus.update_val = 32'd0;
    bus.is_update_dep = 1'b0; bus.update_dep_id = 5'd0; bus.update_dep = 5'd0;
  endtask

  task automatic commit(input logic [4:0] id, input logic [4:0] tag, input logic [31:0] v);
    bus.is_update_val = 1'b1; bus.update_val_id = id; bus.update_val_dep = tag;
    bus.update_val = v;
  endtask

  task automatic rename(input logic [4:0] id, input logic [4:0] tag);
    bus.is_update_dep = 1'b1; bus.update_dep_id = id; bus.update_dep = tag;
  endtask

  // One clock: model follows the edge, returns at the next falling edge.
  task automatic tick();
    @(posedge clk_in);
    m_clock();
    @(negedge clk_in);
  endtask

  task automatic test_reset();
    rst_in = 1'b1; rdy_in = 1'b1; idle();
    bus.qry1_id = 5'd5; bus.qry2_id = 5'd17;
    m_reset();
    #1;
    vectors++;
    if (bus.qry1_val !== 32'd0 || bus.qry1_has_dep !== 1'b0 || bus.qry1_dep !== 5'd0) begin
      miscompares++;
      $display("FAIL reset_q1 got val=%h dep=%b/%0d exp 0/0/0", bus.qry1_val, bus.qry1_has_dep, bus.qry1_dep);
    end
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;
    #1;
    vectors++;
    if (bus.qry2_val !== 32'd0 || bus.qry2_has_dep !== 1'b0 || bus.qry2_dep !== 5'd0) begin
      miscompares++;
      $display("FAIL reset_q2 got val=%h dep=%b/%0d exp 0/0/0", bus.qry2_val, bus.qry2_has_dep, bus.qry2_dep);
    end
  endtask

  task automatic test_x0();
    commit(5'd0, 5'd0, 32'hDEAD); rename(5'd0, 5'd5);
    bus.qry1_id = 5'd0;
    #1;
    vectors++;
    if (bus.qry1_val !== 32'd0 || bus.qry1_has_dep !== 1'b0 || bus.qry1_dep !== 5'd0) begin
      miscompares++;
      $display("FAIL x0_bypass got val=%h dep=%b/%0d exp 0/0/0", bus.qry1_val, bus.qry1_has_dep, bus.qry1_dep);
    end
    tick(); idle(); bus.qry2_id = 5'd0;
    #1;
    vectors++;
    if (bus.qry2_val !== 32'd0 || bus.qry2_has_dep !== 1'b0 || bus.qry2_dep !== 5'd0) begin
      miscompares++;
      $display("FAIL x0_after got val=%h dep=%b/%0d exp 0/0/0", bus.qry2_val, bus.qry2_has_dep, bus.qry2_dep);
    end
  endtask

  task automatic test_rename_commit();
    rename(5'd3, 5'd7); tick(); idle(); bus.qry1_id = 5'd3;
    #1;
    vectors++;
    if (bus.qry1_has_dep !== 1'b1 || bus.qry1_dep !== 5'd7) begin
      miscompares++;
      $display("FAIL rename_x3 got has_dep=%b dep=%0d exp 1/7", bus.qry1_has_dep, bus.qry1_dep);
    end
    commit(5'd3, 5'd7, 32'h1234);
    #1;
    vectors++;
    if (bus.qry1_val !== 32'h1234 || bus.qry1_has_dep !== 1'b0) begin
      miscompares++;
      $display("FAIL commit_bypass got val=%h has_dep=%b exp 1234/0", bus.qry1_val, bus.qry1_has_dep);
    end
    tick(); idle();
    #1;
    vectors++;
    if (bus.qry1_val !== 32'h1234 || bus.qry1_has_dep !== 1'b0) begin
      miscompares++;
      $display("FAIL commit_after got val=%h has_dep=%b exp 1234/0", bus.qry1_val, bus.qry1_has_dep);
    end
  endtask

  task automatic test_younger_rename();
    rename(5'd4, 5'd2); tick(); idle();
    rename(5'd4, 5'd9); tick(); idle();
    commit(5'd4, 5'd2, 32'h55); bus.qry1_id = 5'd4;
    #1;
    vectors++;
    if (bus.qry1_has_dep !== 1'b1 || bus.qry1_dep !== 5'd9) begin
      miscompares++;
      $display("FAIL stale_commit_bypass got has_dep=%b dep=%0d exp 1/9", bus.qry1_has_dep, bus.qry1_dep);
    end
    tick(); idle();
    #1;
    vectors++;
    if (bus.qry1_has_dep !== 1'b1 || bus.qry1_dep !== 5'd9) begin
      miscompares++;
      $display("FAIL stale_commit_after got has_dep=%b dep=%0d exp 1/9", bus.qry1_has_dep, bus.qry1_dep);
    end
    bus.rob_clear = 1'b1; tick(); idle();
    #1;
    vectors++;
    if (bus.qry1_val !== 32'h55 || bus.qry1_has_dep !== 1'b0) begin
      miscompares++;
      $display("FAIL stale_commit_value got val=%h has_dep=%b exp 55/0", bus.qry1_val, bus.qry1_has_dep);
    end
  endtask

  task automatic test_same_cycle();
    commit(5'd6, 5'd1, 32'hAA); rename(5'd6, 5'd4); tick(); idle(); bus.qry2_id = 5'd6;
    #1;
    vectors++;
    if (bus.qry2_has_dep !== 1'b1 || bus.qry2_dep !== 5'd4) begin
      miscompares++;
      $display("FAIL same_cycle_dep got has_dep=%b dep=%0d exp 1/4", bus.qry2_has_dep, bus.qry2_dep);
    end
    bus.rob_clear = 1'b1; tick(); idle();
    #1;
    vectors++;
    if (bus.qry2_val !== 32'hAA || bus.qry2_has_dep !== 1'b0) begin
      miscompares++;
      $display("FAIL same_cycle_val got val=%h has_dep=%b exp aa/0", bus.qry2_val, bus.qry2_has_dep);
    end
  endtask

  task automatic test_rob_clear();
    rename(5'd1, 5'd1); tick(); idle();
    rename(5'd2, 5'd2); tick(); idle();
    rename(5'd31, 5'd5); tick(); idle();
    bus.rob_clear = 1'b1; commit(5'd1, 5'd9, 32'h77); rename(5'd8, 5'd3);
    tick(); idle();
    bus.qry1_id = 5'd1; bus.qry2_id = 5'd2;
    #1;
    vectors++;
    if (bus.qry1_val !== 32'h77 || bus.qry1_has_dep !== 1'b0 || bus.qry2_has_dep !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_x1_x2 got x1=%h/%b x2 has_dep=%b exp 77/0 0",
               bus.qry1_val, bus.qry1_has_dep, bus.qry2_has_dep);
    end
    bus.qry1_id = 5'd31; bus.qry2_id = 5'd8;
    #1;
    vectors++;
    if (bus.qry1_has_dep !== 1'b0 || bus.qry2_has_dep !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_x31_x8 got has_dep=%b/%b exp 0/0", bus.qry1_has_dep, bus.qry2_has_dep);
    end
  endtask

  task automatic test_pause();
    rdy_in = 1'b0; commit(5'd10, 5'd0, 32'hBEEF); rename(5'd11, 5'd6);
    tick(); tick(); rdy_in = 1'b1; idle();
    bus.qry1_id = 5'd10; bus.qry2_id = 5'd11;
    #1;
    vectors++;
    if (bus.qry1_val !== 32'd0 || bus.qry1_has_dep !== 1'b0 || bus.qry2_has_dep !== 1'b0) begin
      miscompares++;
      $display("FAIL pause_hold got x10=%h/%b x11 has_dep=%b exp 0/0 0",
               bus.qry1_val, bus.qry1_has_dep, bus.qry2_has_dep);
    end
  endtask

  task automatic test_async_reset();
    rename(5'd12, 5'd3); commit(5'd13, 5'd0, 32'h99); tick(); idle();
    bus.qry1_id = 5'd12; bus.qry2_id = 5'd13;
    #1;
    vectors++;
    if (bus.qry1_has_dep !== 1'b1 || bus.qry1_dep !== 5'd3 || bus.qry2_val !== 32'h99) begin
      miscompares++;
      $display("FAIL pre_reset got x12=%b/%0d x13=%h exp 1/3 99", bus.qry1_has_dep, bus.qry1_dep, bus.qry2_val);
    end
    #1 rst_in = 1'b1;
    m_reset();
    #1;
    vectors++;
    if (bus.qry1_has_dep !== 1'b0 || bus.qry1_dep !== 5'd0 || bus.qry2_val !== 32'd0) begin
      miscompares++;
      $display("FAIL async_reset got x12=%b/%0d x13=%h exp 0/0 0", bus.qry1_has_dep, bus.qry1_dep, bus.qry2_val);
    end
    @(negedge clk_in);
    rst_in = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] ev;
    logic        eh;
    logic [4:0]  ed;
    for (int n = 0; n < 400; n++) begin
      idle();
      rdy_in = ($urandom_range(0, 7) != 0);
      bus.rob_clear = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 1) == 1)
        commit(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom);
      if ($urandom_range(0, 1) == 1)
        rename(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      bus.qry1_id = 5'($urandom_range(0, 7));
      bus.qry2_id = 5'($urandom_range(0, 31));
      #1;
      m_query(bus.qry1_id, ev, eh, ed);
      vectors++;
      if (bus.qry1_has_dep !== eh || (eh ? bus.qry1_dep !== ed : bus.qry1_val !== ev)) begin
        miscompares++;
        $display("FAIL rand_q1 n=%0d id=%0d got %h/%b/%0d exp %h/%b/%0d", n, bus.qry1_id,
                 bus.qry1_val, bus.qry1_has_dep, bus.qry1_dep, ev, eh, ed);
      end
      m_query(bus.qry2_id, ev, eh, ed);
      vectors++;
      if (bus.qry2_has_dep !== eh || (eh ? bus.qry2_dep !== ed : bus.qry2_val !== ev)) begin
        miscompares++;
        $display("FAIL rand_q2 n=%0d id=%0d got %h/%b/%0d exp %h/%b/%0d", n, bus.qry2_id,
                 bus.qry2_val, bus.qry2_has_dep, bus.qry2_dep, ev, eh, ed);
      end
      tick();
    end
    rdy_in = 1'b1; idle();
  endtask

  initial begin
    test_reset();
    test_x0();
    test_rename_commit();
    test_younger_rename();
    test_same_cycle();
    test_rob_clear();
    test_pause();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
